// File: rtl/write_back_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// write_back_arbiter_pkg
//   Register-file parameters that the write-back path shares with the
//   execution units.
//   - REGISTER_DESCRIPTOR_WIDTH : width of a destination register descriptor
//   - OPERAND_WIDTH             : width of one result / operand
//   - REGISTER_SIZE             : number of architectural registers
//   - grant_index_width()       : width of an index into N requesters
//   - write_back_request_t      : {descriptor, result} as produced by a unit
// -----------------------------------------------------------------------------
package write_back_arbiter_pkg;

  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
  localparam int OPERAND_WIDTH             = 32;
  localparam int REGISTER_SIZE             = 1 << REGISTER_DESCRIPTOR_WIDTH;

  // Register 0 is hardwired and has no storage cell.
  localparam logic [REGISTER_DESCRIPTOR_WIDTH-1:0] ZERO_REGISTER = '0;

  // Index width for n requesters. A single requester still needs one bit
  // so that the index port never collapses to zero width.
  function automatic int grant_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_INDEX_WIDTH = grant_index_width(4);

  // Result as presented by one execution unit.
  typedef struct packed {
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_descriptor;
    logic [OPERAND_WIDTH-1:0]             result;
  } write_back_request_t;

endpackage

// File: rtl/write_back_arbiter_arb.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
//   Purely combinational rotating-priority arbiter. The search starts at
//   `pointer` and wraps modulo WIDTH; the first set request bit wins.
//   Ports:
//     request     in  WIDTH  request vector
//     pointer     in  IDX_W  highest-priority index this cycle (< WIDTH)
//     grant       out WIDTH  one-hot grant, all-zero when nothing requests
//     grant_index out IDX_W  index of the granted bit (0 when none)
//     any_grant   out 1      some request was granted
// -----------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] request,
  input  logic [IDX_W-1:0] pointer,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             any_grant
);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    // Walk the ring once from the pointer; any_grant latches the first hit
    // so later candidates cannot override it.
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(pointer) + k) % WIDTH;
      if (!any_grant && request[idx]) begin
        grant[idx]  = 1'b1;
        grant_index = IDX_W'(idx);
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_back_arbiter.sv
// -----------------------------------------------------------------------------
// write_back_arbiter
//   Shares the register file's single write-back port among REQUESTER_COUNT
//   execution units. One result is accepted per cycle (valid & ready) and
//   appears on the registered write-back outputs on the next clock.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     request_valid_input         per-unit result valid
//     request_register_input      flattened descriptors, unit i at slice i
//     request_result_input        flattened results, unit i at slice i
//     request_ready_output        one-hot grant (transfer on valid & ready)
//     write_back_output           write strobe into the register file
//     write_back_register_output  destination register of the last accept
//     result_output               data of the last accept
//     grant_index_output          index of the last accepted unit (debug)
// -----------------------------------------------------------------------------
module write_back_arbiter
  import write_back_arbiter_pkg::*;
#(
  parameter int REQUESTER_COUNT           = 4,
  parameter int REGISTER_DESCRIPTOR_WIDTH = write_back_arbiter_pkg::REGISTER_DESCRIPTOR_WIDTH,
  parameter int OPERAND_WIDTH             = write_back_arbiter_pkg::OPERAND_WIDTH,
  parameter int GRANT_INDEX_WIDTH         = grant_index_width(REQUESTER_COUNT)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [REQUESTER_COUNT-1:0]                          request_valid_input,
  input  logic [REQUESTER_COUNT*REGISTER_DESCRIPTOR_WIDTH-1:0] request_register_input,
  input  logic [REQUESTER_COUNT*OPERAND_WIDTH-1:0]             request_result_input,
  output logic [REQUESTER_COUNT-1:0]                          request_ready_output,
  output logic                                                write_back_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0]                write_back_register_output,
  output logic [OPERAND_WIDTH-1:0]                            result_output,
  output logic [GRANT_INDEX_WIDTH-1:0]                        grant_index_output
);

  localparam int DW  = REGISTER_DESCRIPTOR_WIDTH;
  localparam int OW  = OPERAND_WIDTH;
  localparam int GIW = GRANT_INDEX_WIDTH;

  logic [GIW-1:0]             ptr_q;
  logic [REQUESTER_COUNT-1:0] gnt;
  logic [GIW-1:0]             gnt_idx;
  logic                       any_gnt;
  logic                       transfer;
  logic [DW-1:0]              sel_reg;
  logic [OW-1:0]              sel_res;
  logic [GIW-1:0]             ptr_nxt;

  round_robin_arbiter #(
    .WIDTH (REQUESTER_COUNT),
    .IDX_W (GIW)
  ) u_arb (
    .request     (request_valid_input),
    .pointer     (ptr_q),
    .grant       (gnt),
    .grant_index (gnt_idx),
    .any_grant   (any_gnt)
  );

  // Ready is masked during reset so no unit believes it handed off a result
  // that the reset branch below is about to drop.
  assign request_ready_output = rst ? '0 : gnt;
  assign transfer             = any_gnt & ~rst;

  assign sel_reg = request_register_input[gnt_idx*DW +: DW];
  assign sel_res = request_result_input[gnt_idx*OW +: OW];

  // Explicit wrap so non-power-of-two counts never leave the ring.
  assign ptr_nxt = (gnt_idx == GIW'(REQUESTER_COUNT-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q                      <= '0;
      write_back_output          <= 1'b0;
      write_back_register_output <= '0;
      result_output              <= '0;
      grant_index_output         <= '0;
    end else begin
      write_back_output <= 1'b0;
      if (transfer) begin
        ptr_q                      <= ptr_nxt;
        write_back_register_output <= sel_reg;
        result_output              <= sel_res;
        grant_index_output         <= gnt_idx;
        // Register 0 consumes its grant but has no cell to write.
        write_back_output          <= (sel_reg != DW'(ZERO_REGISTER));
      end
    end
  end

endmodule

// File: tb/tb_write_back_arbiter.sv
module tb_write_back_arbiter;
  import write_back_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DW  = REGISTER_DESCRIPTOR_WIDTH;
  localparam int OW  = OPERAND_WIDTH;
  localparam int GIW = grant_index_width(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      valid;
  write_back_request_t req [N];
  logic [N*DW-1:0]   flat_reg;
  logic [N*OW-1:0]   flat_res;
  logic [N-1:0]      ready;
  logic              wb;
  logic [DW-1:0]     wb_reg;
  logic [OW-1:0]     wb_res;
  logic [GIW-1:0]    gidx;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int          m_ptr = 0;
  logic        m_wb  = 1'b0;
  logic [DW-1:0] m_reg = '0;
  logic [OW-1:0] m_res = '0;
  int          m_gidx = 0;

  always #5 clk = ~clk;

  always_comb begin
    flat_reg = '0;
    flat_res = '0;
    for (int i = 0; i < N; i++) begin
      flat_reg[i*DW +: DW] = req[i].register_descriptor;
      flat_res[i*OW +: OW] = req[i].result;
    end
  end

  write_back_arbiter #(.REQUESTER_COUNT(N)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .request_valid_input        (valid),
    .request_register_input     (flat_reg),
    .request_result_input       (flat_res),
    .request_ready_output       (ready),
    .write_back_output          (wb),
    .write_back_register_output (wb_reg),
    .result_output              (wb_res),
    .grant_index_output         (gidx)
  );

  // Requester contract: a valid request not taken must stay put.
  logic [N-1:0] prev_valid = '0, prev_ready = '0;
  write_back_request_t prev_req [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (prev_valid[i] && !prev_ready[i])
        assert (valid[i] && req[i] == prev_req[i])
          else $error("FAIL contract unit=%0d dropped or changed before ready", i);
      prev_req[i] = req[i];
    end
    prev_valid = valid;
    prev_ready = ready;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Winner = valid unit with the smallest forward distance from the pointer.
  task automatic pick(input logic [N-1:0] v, input int ptr, output int idx, output bit found);
    int best;
    best  = N;
    idx   = 0;
    found = 0;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - ptr + N) % N) < best) begin
        best  = (i - ptr + N) % N;
        idx   = i;
        found = 1;
      end
  endtask

  task automatic set_req(input int u, input logic [DW-1:0] r, input logic [OW-1:0] d);
    valid[u]                  = 1'b1;
    req[u].register_descriptor = r;
    req[u].result              = d;
  endtask

  // One clock: check combinational ready, clock, check registered outputs.
  // The accepted unit is refilled with random data (refill) or idled.
  task automatic do_cycle(input string tag, input bit refill, output int acc);
    int idx;
    bit found;
    logic [N-1:0] exp_ready;
    pick(valid, m_ptr, idx, found);
    exp_ready = (found && !rst) ? (N'(1) << idx) : '0;
    #1;
    check({tag, ".ready"}, 64'(ready), 64'(exp_ready));
    @(posedge clk);
    acc = -1;
    if (rst) begin
      m_wb = 0; m_reg = '0; m_res = '0; m_gidx = 0; m_ptr = 0;
    end else begin
      m_wb = 0;
      if (found) begin
        m_wb   = (req[idx].register_descriptor != '0);
        m_reg  = req[idx].register_descriptor;
        m_res  = req[idx].result;
        m_gidx = idx;
        m_ptr  = (idx + 1) % N;
        acc    = idx;
      end
    end
    #1;
    check({tag, ".wb"},   64'(wb),     64'(m_wb));
    check({tag, ".reg"},  64'(wb_reg), 64'(m_reg));
    check({tag, ".res"},  64'(wb_res), 64'(m_res));
    check({tag, ".gidx"}, 64'(gidx),   64'(m_gidx));
    if (acc >= 0) begin
      if (refill) set_req(acc, DW'($urandom_range(1, REGISTER_SIZE-1)), $urandom);
      else        valid[acc] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int acc;
    for (int g = 0; g < 4*N && valid != '0; g++) do_cycle(tag, 0, acc);
    check({tag, ".drained"}, 64'(valid), 64'd0);
  endtask

  initial begin
    int acc;
    int seen;
    rst   = 1'b1;
    valid = '0;
    for (int i = 0; i < N; i++) req[i] = '0;

    // Reset then idle
    do_cycle("reset0", 0, acc);
    do_cycle("reset1", 0, acc);
    rst = 1'b0;
    do_cycle("idle", 0, acc);

    // Single request, unit 2
    set_req(2, 5, 32'hDEADBEEF);
    do_cycle("single", 0, acc);
    check("single.lit_gidx", 64'(gidx), 64'd2);
    check("single.lit_res",  64'(wb_res), 64'hDEADBEEF);

    // Full contention from pointer 0: grants 0,1,2,3,0,1,2,3
    rst = 1'b1; do_cycle("rst_a", 0, acc); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, DW'(i + 8), $urandom);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      do_cycle("contend", 1, acc);
      check("contend.lit_order", 64'(gidx), 64'(c % N));
      check("contend.lit_strobe", 64'(wb), 64'd1);
    end
    drain("contend_drain");

    // Register 0: accepted, no strobe, pointer advances to 2
    rst = 1'b1; do_cycle("rst_b", 0, acc); rst = 1'b0;
    set_req(1, 0, 32'h1234);
    do_cycle("reg0", 0, acc);
    check("reg0.lit_wb",   64'(wb),     64'd0);
    check("reg0.lit_gidx", 64'(gidx),   64'd1);
    check("reg0.lit_res",  64'(wb_res), 64'h1234);
    set_req(0, 3, 32'hA0); set_req(1, 4, 32'hA1); set_req(2, 6, 32'hA2);
    do_cycle("reg0_ptr", 0, acc);
    check("reg0.lit_ptr2", 64'(gidx), 64'd2);
    drain("reg0_drain");

    // Same destination with pointer at 3
    rst = 1'b1; do_cycle("rst_c", 0, acc); rst = 1'b0;
    set_req(2, 9, 32'h99);
    do_cycle("samedst_setup", 0, acc);
    set_req(0, 7, 32'h11); set_req(3, 7, 32'h33);
    do_cycle("samedst1", 0, acc);
    check("samedst.lit_first", 64'(wb_res), 64'h33);
    do_cycle("samedst2", 0, acc);
    check("samedst.lit_second", 64'(wb_res), 64'h11);
    check("samedst.lit_reg", 64'(wb_reg), 64'd7);

    // Reset mid-stream
    rst = 1'b1; do_cycle("rst_d", 0, acc); rst = 1'b0;
    set_req(1, 12, 32'hB1); set_req(2, 13, 32'hB2);
    do_cycle("midrst_first", 0, acc);
    rst = 1'b1;
    do_cycle("midrst_rst", 0, acc);
    check("midrst.lit_nostrobe", 64'(wb), 64'd0);
    rst = 1'b0;
    set_req(1, 12, 32'hC1);
    do_cycle("midrst_after1", 0, acc);
    check("midrst.lit_u1", 64'(gidx), 64'd1);
    do_cycle("midrst_after2", 0, acc);
    check("midrst.lit_u2", 64'(gidx), 64'd2);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom), $urandom);
      rst = ($urandom_range(0, 39) == 0);
      do_cycle("random", 0, acc);
    end
    rst = 1'b0;
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
